// File: rtl/binary_to_bcd_seq_if.sv
// Start/busy/done handshake and data bus between a binary source and the
// sequential binary-to-BCD converter.
interface binary_to_bcd_seq_if #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DIGITS = 2
);
    logic                  start;
    logic [WIDTH-1:0]      binary;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    modport master (
        output start,
        output binary,
        input  busy,
        input  done,
        input  bcd
    );

    modport slave (
        input  start,
        input  binary,
        output busy,
        output done,
        output bcd
    );
endinterface

// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with a start/busy/done handshake and a result register that holds between runs.
module binary_to_bcd_seq #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DIGITS = 2
) (
    input  logic               clk,
    input  logic               reset,
    binary_to_bcd_seq_if.slave bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_bin_sr;
    logic [BCD_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [BCD_W-1:0]   r_bcd;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_bin_sr_nxt;
    logic [BCD_W-1:0]   w_scratch_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [BCD_W-1:0]   w_bcd_nxt;

    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_shifted;
    logic [WIDTH-1:0]   w_bin_shifted;

    // Per-digit +3 correction; each digit is independent, no inter-digit carry
    always_comb begin
        w_adj = r_scratch;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_shifted     = BCD_W'({w_adj, r_bin_sr[WIDTH-1]});
    assign w_bin_shifted = WIDTH'({r_bin_sr, 1'b0});

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_bin_sr_nxt  = r_bin_sr;
        w_scratch_nxt = r_scratch;
        w_cnt_nxt     = r_cnt;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_bcd_nxt     = r_bcd;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_bin_sr_nxt  = bus.binary;
                    w_scratch_nxt = '0;
                    w_cnt_nxt     = CNT_W'(WIDTH);
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_bin_sr_nxt  = w_bin_shifted;
                w_scratch_nxt = w_shifted;
                w_cnt_nxt     = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_bcd_nxt   = w_shifted;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_bin_sr  <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bin_sr  <= w_bin_sr_nxt;
            r_scratch <= w_scratch_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_bcd     <= w_bcd_nxt;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.bcd  = r_bcd;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Self-checking bench for binary_to_bcd_seq: 4-bit/2-digit and 8-bit/3-digit
// instances checked against a decimal-arithmetic reference model.
module tb_binary_to_bcd_seq;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    binary_to_bcd_seq_if #(.WIDTH(4), .DIGITS(2)) bus4 ();
    binary_to_bcd_seq_if #(.WIDTH(8), .DIGITS(3)) bus8 ();

    binary_to_bcd_seq #(.WIDTH(4), .DIGITS(2)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.slave)
    );

    // Free-running upstream counter feeding the 8-bit converter
    logic [7:0] counter;
    logic [7:0] direct8;
    logic       use_cnt;
    logic       start8;
    assign bus8.binary = use_cnt ? counter : direct8;
    assign bus8.start  = start8;

    always @(posedge clk or posedge reset) begin
        if (reset) counter <= 8'd0;
        else       counter <= counter + 8'd1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits of v, packed four bits per digit
    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int p;
        r = '0;
        p = 1;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 4-bit conversion with cycle-by-cycle handshake checks
    task automatic conv4(input logic [3:0] v, input string tag);
        logic [7:0] exp_bcd;
        exp_bcd = 8'(to_bcd(int'(v)));
        bus4.start  = 1'b1;
        bus4.binary = v;
        tick();
        bus4.start = 1'b0;
        checks++;
        if (bus4.busy !== 1'b1 || bus4.done !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b done=%b, want busy=1 done=0", tag, bus4.busy, bus4.done);
        end
        for (int k = 1; k <= 4; k++) begin
            bus4.binary = 4'($urandom);
            tick();
            checks++;
            if (k < 4) begin
                if (bus4.busy !== 1'b1 || bus4.done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s shift%0d: busy=%b done=%b, want busy=1 done=0", tag, k, bus4.busy, bus4.done);
                end
            end else begin
                if (bus4.busy !== 1'b0 || bus4.done !== 1'b1 || bus4.bcd !== exp_bcd) begin
                    errors++;
                    $display("FAIL %s result: busy=%b done=%b bcd=%h, want busy=0 done=1 bcd=%h",
                             tag, bus4.busy, bus4.done, bus4.bcd, exp_bcd);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus4.start  = 1'b0;
        bus4.binary = '0;
        start8      = 1'b0;
        direct8     = '0;
        use_cnt     = 1'b0;
        #13;
        checks++;
        if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.bcd !== 8'h00 ||
            bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.bcd !== 12'h000) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b bcd=%h busy8=%b done8=%b bcd8=%h, want all zero",
                     bus4.busy, bus4.done, bus4.bcd, bus8.busy, bus8.done, bus8.bcd);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        conv4(4'd15, "single15");
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus4.done !== 1'b0 || bus4.bcd !== 8'h15) begin
                errors++;
                $display("FAIL hold%0d: done=%b bcd=%h, want done=0 bcd=15", k, bus4.done, bus4.bcd);
            end
        end
    endtask

    task automatic test_boundaries();
        conv4(4'd0,  "bound0");
        conv4(4'd9,  "bound9");
        conv4(4'd10, "bound10");
        conv4(4'd15, "bound15");
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            tick();
            conv4(4'($urandom_range(15)), "random");
        end
    endtask

    task automatic test_busy_protect();
        int n_done;
        int done_edge;
        logic [7:0] got;
        n_done = 0;
        done_edge = -1;
        got = '0;
        tick();
        bus4.start  = 1'b1;
        bus4.binary = 4'd6;
        tick();
        for (int i = 1; i <= 10; i++) begin
            if (i == 2) begin
                bus4.start  = 1'b1;
                bus4.binary = 4'd13;
            end else begin
                bus4.start = 1'b0;
            end
            tick();
            if (bus4.done === 1'b1) begin
                n_done++;
                done_edge = i;
                got = bus4.bcd;
            end
        end
        checks++;
        if (n_done != 1 || done_edge != 4 || got !== 8'h06) begin
            errors++;
            $display("FAIL busy_protect: dones=%0d edge=%0d bcd=%h, want dones=1 edge=4 bcd=06",
                     n_done, done_edge, got);
        end
    endtask

    task automatic test_back_to_back();
        tick();
        conv4(4'd7, "b2b_first");
        // done is high now; the second start is sampled on the next edge
        bus4.start  = 1'b1;
        bus4.binary = 4'd12;
        tick();
        bus4.start = 1'b0;
        checks++;
        if (bus4.busy !== 1'b1 || bus4.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b accept: busy=%b done=%b, want busy=1 done=0", bus4.busy, bus4.done);
        end
        for (int k = 1; k <= 4; k++) begin
            bus4.binary = 4'($urandom);
            tick();
            checks++;
            if (k < 4) begin
                if (bus4.done !== 1'b0 || bus4.bcd !== 8'h07) begin
                    errors++;
                    $display("FAIL b2b shift%0d: done=%b bcd=%h, want done=0 bcd=07", k, bus4.done, bus4.bcd);
                end
            end else if (bus4.done !== 1'b1 || bus4.bcd !== 8'h12) begin
                errors++;
                $display("FAIL b2b second: done=%b bcd=%h, want done=1 bcd=12", bus4.done, bus4.bcd);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n_done;
        tick();
        bus4.start  = 1'b1;
        bus4.binary = 4'd11;
        tick();
        bus4.start = 1'b0;
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.bcd !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid async: busy=%b done=%b bcd=%h, want 0 0 00", bus4.busy, bus4.done, bus4.bcd);
        end
        tick();
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus4.done === 1'b1) n_done++;
        end
        checks++;
        if (n_done != 0 || bus4.bcd !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid no_done: dones=%0d bcd=%h, want 0 and 00", n_done, bus4.bcd);
        end
        conv4(4'd3, "after_reset3");
    endtask

    task automatic conv8_direct(input logic [7:0] v);
        bit seen;
        logic [11:0] exp_bcd;
        exp_bcd = 12'(to_bcd(int'(v)));
        seen = 1'b0;
        use_cnt = 1'b0;
        direct8 = v;
        start8  = 1'b1;
        tick();
        start8 = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (bus8.done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || bus8.bcd !== exp_bcd) begin
            errors++;
            $display("FAIL conv8 %0d: seen_done=%0d bcd=%h, want bcd=%h", v, seen, bus8.bcd, exp_bcd);
        end
    endtask

    task automatic test_counter_driven();
        logic [7:0] captured;
        bit seen;
        conv8_direct(8'd255);
        conv8_direct(8'd200);
        conv8_direct(8'($urandom));
        repeat ($urandom_range(7)) tick();
        use_cnt = 1'b1;
        for (int n = 0; n < 30; n++) begin
            captured = counter;
            start8 = 1'b1;
            tick();
            start8 = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                tick();
                if (bus8.done === 1'b1) seen = 1'b1;
            end
            checks++;
            if (!seen || bus8.bcd !== 12'(to_bcd(int'(captured)))) begin
                errors++;
                $display("FAIL counter %0d: seen_done=%0d bcd=%h, want bcd=%h",
                         captured, seen, bus8.bcd, 12'(to_bcd(int'(captured))));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_boundaries();
        test_random();
        test_busy_protect();
        test_back_to_back();
        test_reset_mid();
        test_counter_driven();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
